// File: rtl/sram_like_arbiter.sv
// Two-master (instruction/data) arbiter onto one SRAM-like port, one transaction outstanding.
// Define ARB_RR_EN for round-robin tie breaking; otherwise the data side has fixed priority.
module sram_like_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [70:0] inst_cmd,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [70:0] data_cmd,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_req,
  output logic [70:0] sram_cmd,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata
);

  localparam int unsigned CMD_W = 71;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic               owner_data;
  logic [CMD_W-1:0]   cmd_q;
  logic               grant_data_c;

`ifdef ARB_RR_EN
  logic               last_data;

  // On a tie, the side that was not granted last wins.
  assign grant_data_c = data_req && (!inst_req || !last_data);
`else
  assign grant_data_c = data_req;
`endif

  // Arbitration state, owner and latched command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner_data <= 1'b1;
      cmd_q      <= '0;
`ifdef ARB_RR_EN
      last_data  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (inst_req || data_req) begin
            owner_data <= grant_data_c;
            cmd_q      <= grant_data_c ? data_cmd : inst_cmd;
            state      <= REQ;
          end
        end
        REQ: begin
          if (sram_addr_ok) begin
            state     <= RESP;
`ifdef ARB_RR_EN
            last_data <= owner_data;
`endif
          end
        end
        RESP: begin
          if (sram_data_ok) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshakes pass straight through to the current owner only.
  assign sram_req     = (state == REQ);
  assign sram_cmd     = cmd_q;
  assign inst_addr_ok = (state == REQ)  && !owner_data && sram_addr_ok;
  assign data_addr_ok = (state == REQ)  &&  owner_data && sram_addr_ok;
  assign inst_data_ok = (state == RESP) && !owner_data && sram_data_ok;
  assign data_data_ok = (state == RESP) &&  owner_data && sram_data_ok;
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter.
module tb_sram_like_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [70:0] inst_cmd;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [70:0] data_cmd;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_req;
  logic [70:0] sram_cmd;
  logic        sram_addr_ok;
  logic        sram_data_ok;
  logic [31:0] sram_rdata;

  int n_cmp;
  int n_err;

  localparam logic [70:0] C_INST = {1'b0, 2'b10, 4'b1111, 32'hBFC0_0000, 32'h0000_0000};
  localparam logic [70:0] C_I2   = {1'b0, 2'b10, 4'b1111, 32'hBFC0_0004, 32'h0000_0000};
  localparam logic [70:0] C_D2   = {1'b0, 2'b10, 4'b1111, 32'h8000_0100, 32'h0000_0000};
  localparam logic [70:0] C_I3   = {1'b0, 2'b10, 4'b1111, 32'hBFC0_0008, 32'h0000_0000};
  localparam logic [70:0] C_D3   = {1'b1, 2'b10, 4'b1111, 32'h8000_0200, 32'h1234_5678};
  localparam logic [70:0] C_W    = {1'b1, 2'b10, 4'b0011, 32'h8000_0010, 32'hDEAD_BEEF};
  localparam logic [70:0] C_I6   = {1'b0, 2'b10, 4'b1111, 32'hBFC0_0010, 32'h0000_0000};
  localparam logic [70:0] C_I7   = {1'b0, 2'b10, 4'b1111, 32'hBFC0_0014, 32'h0000_0000};

  sram_like_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_cmd     (inst_cmd),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_cmd     (data_cmd),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_req     (sram_req),
    .sram_cmd     (sram_cmd),
    .sram_addr_ok (sram_addr_ok),
    .sram_data_ok (sram_data_ok),
    .sram_rdata   (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [70:0] got, input logic [70:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One tied arbitration with both requests held high; slave answers at minimum latency.
  task automatic run_tie(input bit exp_data);
    #1;
    tick();
    sram_addr_ok = 1'b1;
    #1;
    check("tie_cmd", sram_cmd, exp_data ? C_D3 : C_I3);
    check("tie_data_addr_ok", 71'(data_addr_ok), 71'(exp_data));
    check("tie_inst_addr_ok", 71'(inst_addr_ok), 71'(!exp_data));
    tick();
    sram_addr_ok = 1'b0;
    sram_data_ok = 1'b1;
    #1;
    check("tie_data_data_ok", 71'(data_data_ok), 71'(exp_data));
    check("tie_inst_data_ok", 71'(inst_data_ok), 71'(!exp_data));
    tick();
    sram_data_ok = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit exp_tie [3];
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    inst_req = 1'b0;
    inst_cmd = '0;
    data_req = 1'b0;
    data_cmd = '0;
    sram_addr_ok = 1'b0;
    sram_data_ok = 1'b0;
    sram_rdata = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_sram_req", 71'(sram_req), 71'(0));
    check("rst_sram_cmd", sram_cmd, 71'(0));
    check("rst_addr_ok", 71'({inst_addr_ok, data_addr_ok}), 71'(0));
    check("rst_data_ok", 71'({inst_data_ok, data_data_ok}), 71'(0));

    // Instruction-only read, slave answers two cycles after addr_ok
    inst_req = 1'b1;
    inst_cmd = C_INST;
    #1;
    check("t1_idle_sram_req", 71'(sram_req), 71'(0));
    tick();
    inst_req = 1'b0;
    sram_addr_ok = 1'b1;
    #1;
    check("t1_sram_req", 71'(sram_req), 71'(1));
    check("t1_sram_cmd", sram_cmd, C_INST);
    check("t1_inst_addr_ok", 71'(inst_addr_ok), 71'(1));
    check("t1_data_addr_ok", 71'(data_addr_ok), 71'(0));
    tick();
    sram_addr_ok = 1'b0;
    #1;
    check("t1_resp_sram_req", 71'(sram_req), 71'(0));
    check("t1_wait_inst_data_ok", 71'(inst_data_ok), 71'(0));
    tick();
    sram_data_ok = 1'b1;
    sram_rdata = 32'h3C1D_0001;
    #1;
    check("t1_inst_data_ok", 71'(inst_data_ok), 71'(1));
    check("t1_inst_rdata", 71'(inst_rdata), 71'(32'h3C1D_0001));
    check("t1_data_data_ok", 71'(data_data_ok), 71'(0));
    tick();
    sram_data_ok = 1'b0;
    #1;
    check("t1_back_idle", 71'(sram_req), 71'(0));
    check("t1_idle_inst_data_ok", 71'(inst_data_ok), 71'(0));

    // Simultaneous requests: data first, inst after data_ok
    inst_req = 1'b1;
    data_req = 1'b1;
    inst_cmd = C_I2;
    data_cmd = C_D2;
    #1;
    tick();
    sram_addr_ok = 1'b1;
    #1;
    check("t2_first_cmd", sram_cmd, C_D2);
    check("t2_data_addr_ok", 71'(data_addr_ok), 71'(1));
    check("t2_inst_addr_ok", 71'(inst_addr_ok), 71'(0));
    tick();
    sram_addr_ok = 1'b0;
    data_req = 1'b0;
    sram_data_ok = 1'b1;
    #1;
    check("t2_data_data_ok", 71'(data_data_ok), 71'(1));
    check("t2_inst_data_ok", 71'(inst_data_ok), 71'(0));
    tick();
    sram_data_ok = 1'b0;
    #1;
    check("t2_idle_sram_req", 71'(sram_req), 71'(0));
    tick();
    sram_addr_ok = 1'b1;
    #1;
    check("t2_second_cmd", sram_cmd, C_I2);
    check("t2_second_inst_addr_ok", 71'(inst_addr_ok), 71'(1));
    tick();
    sram_addr_ok = 1'b0;
    inst_req = 1'b0;
    sram_data_ok = 1'b1;
    #1;
    check("t2_second_inst_data_ok", 71'(inst_data_ok), 71'(1));
    tick();
    sram_data_ok = 1'b0;

    // Back-to-back ties; last grant so far was inst
`ifdef ARB_RR_EN
    exp_tie = '{1'b1, 1'b0, 1'b1};
`else
    exp_tie = '{1'b1, 1'b1, 1'b1};
`endif
    inst_req = 1'b1;
    data_req = 1'b1;
    inst_cmd = C_I3;
    data_cmd = C_D3;
    for (int i = 0; i < 3; i++) run_tie(exp_tie[i]);
    inst_req = 1'b0;
    data_req = 1'b0;
    #1;
    tick();

    // Data write stalled 5 cycles in REQ while requests toggle
    data_req = 1'b1;
    data_cmd = C_W;
    #1;
    tick();
    for (int i = 0; i < 5; i++) begin
      data_req = i[0];
      inst_req = ~i[0];
      sram_addr_ok = 1'b0;
      #1;
      check("t4_stall_cmd", sram_cmd, C_W);
      check("t4_stall_sram_req", 71'(sram_req), 71'(1));
      check("t4_stall_addr_ok", 71'({inst_addr_ok, data_addr_ok}), 71'(0));
      tick();
    end
    data_req = 1'b0;
    inst_req = 1'b0;
    sram_addr_ok = 1'b1;
    #1;
    check("t4_cmd", sram_cmd, C_W);
    check("t4_data_addr_ok", 71'(data_addr_ok), 71'(1));
    check("t4_inst_addr_ok", 71'(inst_addr_ok), 71'(0));
    tick();
    sram_addr_ok = 1'b0;
    sram_data_ok = 1'b1;
    #1;
    check("t4_data_data_ok", 71'(data_data_ok), 71'(1));
    tick();
    sram_data_ok = 1'b0;

    // Stray slave strobes while idle
    sram_data_ok = 1'b1;
    sram_addr_ok = 1'b1;
    #1;
    check("t5_stray_data_ok", 71'({inst_data_ok, data_data_ok}), 71'(0));
    check("t5_stray_addr_ok", 71'({inst_addr_ok, data_addr_ok}), 71'(0));
    check("t5_stray_sram_req", 71'(sram_req), 71'(0));
    tick();
    sram_data_ok = 1'b0;
    sram_addr_ok = 1'b0;
    #1;
    check("t5_still_idle", 71'(sram_req), 71'(0));
    tick();

    // Reset in RESP, late data_ok ignored, then a fresh inst grant
    inst_req = 1'b1;
    inst_cmd = C_I6;
    #1;
    tick();
    inst_req = 1'b0;
    sram_addr_ok = 1'b1;
    #1;
    tick();
    sram_addr_ok = 1'b0;
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    sram_data_ok = 1'b1;
    #1;
    check("t6_late_data_ok", 71'({inst_data_ok, data_data_ok}), 71'(0));
    check("t6_rst_sram_req", 71'(sram_req), 71'(0));
    check("t6_rst_sram_cmd", sram_cmd, 71'(0));
    tick();
    sram_data_ok = 1'b0;
    inst_req = 1'b1;
    inst_cmd = C_I7;
    #1;
    check("t6_idle_sram_req", 71'(sram_req), 71'(0));
    tick();
    inst_req = 1'b0;
    sram_addr_ok = 1'b1;
    #1;
    check("t6_sram_req", 71'(sram_req), 71'(1));
    check("t6_sram_cmd", sram_cmd, C_I7);
    check("t6_inst_addr_ok", 71'(inst_addr_ok), 71'(1));
    tick();
    sram_addr_ok = 1'b0;
    sram_data_ok = 1'b1;
    sram_rdata = 32'hA5A5_0F0F;
    #1;
    check("t6_inst_data_ok", 71'(inst_data_ok), 71'(1));
    check("t6_data_rdata", 71'(data_rdata), 71'(32'hA5A5_0F0F));
    tick();
    sram_data_ok = 1'b0;
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
